// File: rtl/alu_pkg.sv
// Shared select codes and FSM encoding for the ALU control decoder and the EX-stage executor.
package alu_pkg;

  localparam int unsigned SEL_W = 4;

  localparam logic [SEL_W-1:0] SEL_AND = 4'b0000;
  localparam logic [SEL_W-1:0] SEL_OR  = 4'b0001;
  localparam logic [SEL_W-1:0] SEL_ADD = 4'b0010;
  localparam logic [SEL_W-1:0] SEL_MUL = 4'b0011;
  localparam logic [SEL_W-1:0] SEL_DIV = 4'b0100;
  localparam logic [SEL_W-1:0] SEL_SUB = 4'b0110;
  localparam logic [SEL_W-1:0] SEL_SLT = 4'b0111;
  localparam logic [SEL_W-1:0] SEL_NOP = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_seq_exec_if.sv
// Request/response bundle between the EX-stage controller (master) and the executor (slave).
interface alu_seq_exec_if #(
  parameter int unsigned WIDTH = 32
);
  import alu_pkg::*;

  logic             start;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;

  modport master (
    output start, sel, a, b,
    input  busy, done, result, hi, zero
  );

  modport slave (
    input  start, sel, a, b,
    output busy, done, result, hi, zero
  );

endinterface

// File: rtl/alu_iter_muldiv.sv
// Iterative radix-2 unsigned multiplier / restoring divider sharing one shift register pair and adder.
module alu_iter_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last_c,
  output logic [WIDTH-1:0] lo_c,
  output logic [WIDTH-1:0] hi_c
);

  localparam int unsigned SW = WIDTH + 2;

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             div_q;

  logic [WIDTH:0]   base;
  logic [WIDTH:0]   addend;
  logic [SW-1:0]    sum;
  logic             ge;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;

  // One adder: acc + (multiplier lsb ? multiplicand : 0) for MUL, {rem,next dividend bit} - divisor for DIV
  always_comb begin
    base   = {1'b0, hi_q};
    addend = lo_q[0] ? {1'b0, opnd_q} : '0;
    if (div_q) begin
      base   = {hi_q, lo_q[WIDTH-1]};
      addend = ~{1'b0, opnd_q};
    end
    sum = {1'b0, base} + {1'b0, addend} + SW'(div_q);
    ge  = sum[SW-1];

    if (div_q) begin
      hi_n = ge ? sum[WIDTH-1:0] : base[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], ge};
    end else begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo_q[WIDTH-1:1]};
    end

    last_c = (cnt_q == CNT_W'(1));
    lo_c   = lo_n;
    hi_c   = hi_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else if (load) begin
      hi_q   <= '0;
      lo_q   <= a;
      opnd_q <= b;
      cnt_q  <= CNT_W'(WIDTH);
      div_q  <= op_div;
    end else if (cnt_q != '0) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq_exec.sv
// EX-stage executor: single-cycle logic/arith ops in place, MUL/DIV delegated to the iterative engine.
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  alu_seq_exec_if.slave   bus
);

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  logic             load_c;
  logic             op_div_c;
  logic             last_c;
  logic [WIDTH-1:0] it_lo_c;
  logic [WIDTH-1:0] it_hi_c;
  logic [WIDTH-1:0] alu_c;
  logic             slt_c;

  alu_iter_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (load_c),
    .op_div (op_div_c),
    .a      (bus.a),
    .b      (bus.b),
    .last_c (last_c),
    .lo_c   (it_lo_c),
    .hi_c   (it_hi_c)
  );

  // Single-cycle ops; unlisted codes fall through to ADD
  always_comb begin
    slt_c = ($signed(bus.a) < $signed(bus.b));
    case (bus.sel)
      SEL_AND: alu_c = bus.a & bus.b;
      SEL_OR:  alu_c = bus.a | bus.b;
      SEL_SUB: alu_c = bus.a - bus.b;
      SEL_SLT: alu_c = {{(WIDTH-1){1'b0}}, slt_c};
      SEL_NOP: alu_c = '0;
      default: alu_c = bus.a + bus.b;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    hi_d     = hi_q;
    load_c   = 1'b0;
    op_div_c = (bus.sel == SEL_DIV);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.sel == SEL_MUL) begin
            load_c  = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_MUL;
          end else if (op_div_c && (bus.b == '0)) begin
            result_d = '1;
            hi_d     = bus.a;
            done_d   = 1'b1;
          end else if (op_div_c) begin
            load_c  = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_DIV;
          end else begin
            result_d = alu_c;
            hi_d     = '0;
            done_d   = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (last_c) begin
          result_d = it_lo_c;
          hi_d     = it_hi_c;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b1;
      result_q <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      hi_q     <= hi_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.zero   = zero_q;
  assign bus.result = result_q;
  assign bus.hi     = hi_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed corner cases plus randomized ops vs. an arithmetic model.
module tb_alu_seq_exec;

  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  alu_seq_exec_if #(.WIDTH(W)) bus();

  alu_seq_exec #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operation's definition
  task automatic model(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic [W-1:0] h, output int lat);
    logic [2*W-1:0] p;
    h   = '0;
    lat = 1;
    case (s)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0011: begin
        p   = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        r   = p[W-1:0];
        h   = p[2*W-1:W];
        lat = W + 1;
      end
      4'b0100: begin
        if (y == '0) begin
          r = '1;
          h = x;
        end else begin
          r   = x / y;
          h   = x % y;
          lat = W + 1;
        end
      end
      4'b0110: r = x - y;
      4'b0111: r = (int'(x) < int'(y)) ? 32'd1 : 32'd0;
      4'b1000: r = '0;
      default: r = x + y;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, scramble operands afterwards, wait for done and check everything
  task automatic run_op(input string tag, input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] er, eh;
    int el, lat, bc;
    model(s, x, y, er, eh, el);
    bus.sel   = s;
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    lat = 1;
    bc  = bus.busy ? 1 : 0;
    while (!bus.done && lat < 100) begin
      step();
      lat++;
      if (bus.busy) bc++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(el));
    chk({tag, ".busy_cycles"}, 64'(bc), 64'(el - 1));
    chk({tag, ".result"}, 64'(bus.result), 64'(er));
    chk({tag, ".hi"}, 64'(bus.hi), 64'(eh));
    chk({tag, ".zero"}, 64'(bus.zero), 64'(er == '0));
    step();
    chk({tag, ".done_drop"}, 64'(bus.done), 64'(0));
  endtask

  initial begin
    logic [3:0]   s;
    logic [W-1:0] x, y, er, eh, mr, mh;
    logic [3:0]   one_cyc [4];
    int           el, dones, done_at;

    vectors     = 0;
    miscompares = 0;
    bus.start   = 1'b0;
    bus.sel     = '0;
    bus.a       = '0;
    bus.b       = '0;
    rst         = 1'b1;
    step();
    chk("reset.busy", 64'(bus.busy), 64'(0));
    chk("reset.done", 64'(bus.done), 64'(0));
    chk("reset.result", 64'(bus.result), 64'(0));
    chk("reset.hi", 64'(bus.hi), 64'(0));
    chk("reset.zero", 64'(bus.zero), 64'(1));
    step();
    rst = 1'b0;
    step();

    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1);
    run_op("sub_neg", 4'b0110, 32'd5, 32'd7);
    run_op("slt_signed", 4'b0111, 32'hFFFF_FFFF, 32'd1);
    run_op("slt_false", 4'b0111, 32'd1, 32'hFFFF_FFFF);
    run_op("undef_as_add", 4'b1010, 32'd3, 32'd4);
    run_op("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00);
    run_op("or", 4'b0001, 32'hF000_0001, 32'h0000_1000);
    run_op("nop", 4'b1000, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op("mul_hi_only", 4'b0011, 32'h0001_0000, 32'h0003_0000);
    run_op("mul_max", 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_100_7", 4'b0100, 32'd100, 32'd7);
    run_op("div_by_zero", 4'b0100, 32'd100, 32'd0);
    run_op("div_max", 4'b0100, 32'hFFFF_FFFF, 32'd1);

    // Back-to-back single-cycle ops: done stays high, one result per cycle
    one_cyc[0] = 4'b0010;
    one_cyc[1] = 4'b0110;
    one_cyc[2] = 4'b0000;
    one_cyc[3] = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      x = $urandom;
      y = $urandom;
      model(one_cyc[i], x, y, er, eh, el);
      bus.sel   = one_cyc[i];
      bus.a     = x;
      bus.b     = y;
      bus.start = 1'b1;
      step();
      chk("b2b.done", 64'(bus.done), 64'(1));
      chk("b2b.result", 64'(bus.result), 64'(er));
      chk("b2b.busy", 64'(bus.busy), 64'(0));
    end
    bus.start = 1'b0;
    step();
    chk("b2b.done_drop", 64'(bus.done), 64'(0));

    // MUL with start hammered through busy and FIN: must be ignored
    x = 32'h0001_2345;
    y = 32'h0000_0321;
    model(4'b0011, x, y, mr, mh, el);
    bus.sel   = 4'b0011;
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    step();
    dones   = 0;
    done_at = 0;
    er      = '0;
    eh      = '0;
    for (int i = 1; i <= 40; i++) begin
      if (bus.done) begin
        dones++;
        done_at = i;
        er = bus.result;
        eh = bus.hi;
      end
      bus.start = (i <= 33);
      bus.sel   = 4'($urandom_range(0, 15));
      bus.a     = $urandom;
      bus.b     = $urandom;
      step();
    end
    bus.start = 1'b0;
    chk("ignore.dones", 64'(dones), 64'(1));
    chk("ignore.done_at", 64'(done_at), 64'(W + 1));
    chk("ignore.result", 64'(er), 64'(mr));
    chk("ignore.hi", 64'(eh), 64'(mh));

    // Async reset mid-DIV abandons the op
    bus.sel   = 4'b0100;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    chk("middiv.busy_before", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    #1;
    chk("middiv.busy", 64'(bus.busy), 64'(0));
    chk("middiv.done", 64'(bus.done), 64'(0));
    chk("middiv.result", 64'(bus.result), 64'(0));
    chk("middiv.hi", 64'(bus.hi), 64'(0));
    chk("middiv.zero", 64'(bus.zero), 64'(1));
    step();
    rst = 1'b0;
    repeat (3) begin
      step();
      chk("postrst.quiet", 64'({bus.busy, bus.done}), 64'(0));
    end
    run_op("postrst_add", 4'b0010, 32'd2, 32'd2);

    // Randomized ops across every select code, DIV often by zero or small divisors
    for (int i = 0; i < 40; i++) begin
      s = 4'($urandom_range(0, 15));
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       y = '0;
        1:       y = $urandom >> $urandom_range(20, 31);
        default: y = $urandom;
      endcase
      run_op($sformatf("rand%0d_sel%0h", i, s), s, x, y);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
